// File: rtl/lbm_pkg.sv
// Shared types and constants for the D2Q9 lattice-Boltzmann datapath.
package lbm_pkg;

    // Number of D2Q9 distribution directions stored per lattice cell.
    localparam int DIR_COUNT = 9;

    // Default cell address width (2**13 covers the 4800-cell lattice).
    localparam int CELL_ADDR_W = 13;
    typedef logic [CELL_ADDR_W-1:0] cell_addr_t;

    // Collision sweep sequencer states.
    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } sched_state_t;

endpackage

// File: rtl/valid_addr_delay.sv
// Fixed-depth shift register carrying a valid flag and a cell address.
// Used to track each issued read through the BRAM and the collision pipe.
module valid_addr_delay #(
    parameter int DEPTH  = 1,
    parameter int ADDR_W = 13
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic              valid_o,
    output logic [ADDR_W-1:0] addr_o
);

    logic [DEPTH-1:0]             valid_q;
    logic [DEPTH-1:0][ADDR_W-1:0] addr_q;

    // Shift valid/address one stage per cycle; a reset drops every in-flight cell.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            // NOTE: this short delay line is cleared on reset so an aborted sweep
            // cannot leak stale write strobes after release; large RAMs are never reset.
            valid_q <= '0;
            addr_q  <= '0;
        end else begin
            valid_q[0] <= valid_i;
            addr_q[0]  <= addr_i;
            for (int i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                addr_q[i]  <= addr_q[i-1];
            end
        end
    end

    assign valid_o = valid_q[DEPTH-1];
    assign addr_o  = addr_q[DEPTH-1];

endmodule

// File: rtl/collision_scheduler.sv
// Sequences one collision sweep over the lattice BRAM: one read per cycle on
// port A, collision data-valid aligned to BRAM read data, and the write-back
// strobe on port B when the matching result leaves the collision pipe.
module collision_scheduler
    import lbm_pkg::*;
#(
    parameter int NUM_CELLS   = 4800,
    parameter int ADDR_W      = 13,
    parameter int RD_LAT      = 2,
    parameter int COLLIDE_LAT = 20
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              start_in,
    input  logic              pause_in,
    output logic              rd_en_out,
    output logic [ADDR_W-1:0] rd_addr_out,
    output logic              collide_valid_out,
    output logic              wr_en_out,
    output logic [ADDR_W-1:0] wr_addr_out,
    output logic              busy_out,
    output logic              done_out,
    output logic [15:0]       sweep_count_out
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_CELLS - 1);

    sched_state_t      state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       sweep_count_q, sweep_count_d;
    logic              rd_en;
    logic [ADDR_W-1:0] col_addr;

    // State, issue counter and sweep counter registers.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            sweep_count_q <= '0;
        end else begin
            // NOTE: non-blocking assignments make every register update from the
            // same pre-edge values, independent of statement order.
            state_q       <= state_d;
            addr_q        <= addr_d;
            sweep_count_q <= sweep_count_d;
        end
    end

    // Next-state logic: issue reads in ascending order, then wait for the last write.
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned (no latches).
        state_d       = state_q;
        addr_d        = addr_q;
        sweep_count_d = sweep_count_q;
        rd_en         = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_in) begin
                    state_d = ISSUE;
                    addr_d  = '0;
                end
            end
            ISSUE: begin
                if (!pause_in) begin
                    rd_en = 1'b1;
                    if (addr_q == LAST_ADDR) begin
                        addr_d  = '0;
                        state_d = DRAIN;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (wr_en_out && (wr_addr_out == LAST_ADDR)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                sweep_count_d = sweep_count_q + 16'd1;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // BRAM read latency: data (and its address) become valid RD_LAT cycles after the read.
    valid_addr_delay #(
        .DEPTH  (RD_LAT),
        .ADDR_W (ADDR_W)
    ) u_rd_delay (
        .clk_i   (clk_in),
        .rst_i   (rst_in),
        .valid_i (rd_en),
        .addr_i  (addr_q),
        .valid_o (collide_valid_out),
        .addr_o  (col_addr)
    );

    // Collision pipe latency: the result for that cell is ready COLLIDE_LAT cycles later.
    valid_addr_delay #(
        .DEPTH  (COLLIDE_LAT),
        .ADDR_W (ADDR_W)
    ) u_col_delay (
        .clk_i   (clk_in),
        .rst_i   (rst_in),
        .valid_i (collide_valid_out),
        .addr_i  (col_addr),
        .valid_o (wr_en_out),
        .addr_o  (wr_addr_out)
    );

    assign rd_en_out       = rd_en;
    assign rd_addr_out     = addr_q;
    assign busy_out        = (state_q == ISSUE) || (state_q == DRAIN);
    assign done_out        = (state_q == DONE);
    assign sweep_count_out = sweep_count_q;

endmodule

// File: tb/tb_collision_scheduler.sv
// Scoreboard bench for collision_scheduler with NUM_CELLS=4, RD_LAT=2, COLLIDE_LAT=20.
module tb_collision_scheduler;

    localparam int NUM_CELLS   = 4;
    localparam int ADDR_W      = 13;
    localparam int RD_LAT      = 2;
    localparam int COLLIDE_LAT = 20;
    localparam int D           = RD_LAT + COLLIDE_LAT;

    logic              clk_in   = 1'b0;
    logic              rst_in   = 1'b1;
    logic              start_in = 1'b0;
    logic              pause_in = 1'b0;
    logic              rd_en_out;
    logic [ADDR_W-1:0] rd_addr_out;
    logic              collide_valid_out;
    logic              wr_en_out;
    logic [ADDR_W-1:0] wr_addr_out;
    logic              busy_out;
    logic              done_out;
    logic [15:0]       sweep_count_out;

    collision_scheduler #(
        .NUM_CELLS   (NUM_CELLS),
        .ADDR_W      (ADDR_W),
        .RD_LAT      (RD_LAT),
        .COLLIDE_LAT (COLLIDE_LAT)
    ) dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .start_in          (start_in),
        .pause_in          (pause_in),
        .rd_en_out         (rd_en_out),
        .rd_addr_out       (rd_addr_out),
        .collide_valid_out (collide_valid_out),
        .wr_en_out         (wr_en_out),
        .wr_addr_out       (wr_addr_out),
        .busy_out          (busy_out),
        .done_out          (done_out),
        .sweep_count_out   (sweep_count_out)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    typedef struct { int cyc; int addr; }  ev_t;
    typedef struct { int cyc; int count; } done_t;
    typedef logic [8:0][7:0] cell_t;

    ev_t   exp_rd[$];
    ev_t   exp_cv[$];
    ev_t   exp_wr[$];
    done_t exp_done[$];

    // BRAM and collision model
    cell_t mem  [NUM_CELLS];
    cell_t snap [NUM_CELLS];
    int    wcnt [NUM_CELLS];
    int    rd_model[$];
    cell_t pipe[$];

    int vectors     = 0;
    int miscompares = 0;

    bit          count_pending = 1'b0;
    logic [15:0] pending_count = '0;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Bounce-back collision: every direction is reversed.
    function automatic cell_t bounce(input cell_t c);
        cell_t r;
        for (int d = 0; d < 9; d++) r[d] = c[8-d];
        return r;
    endfunction

    // Monitor: pop and compare whenever the DUT presents an event.
    always @(negedge clk_in) begin
        ev_t   e;
        done_t dn;
        cell_t dat;
        int    a;
        if (rst_in) begin
            rd_model.delete();
            pipe.delete();
            for (int i = 0; i < NUM_CELLS; i++) wcnt[i] = 0;
            count_pending = 1'b0;
        end else begin
            if (count_pending) begin
                check("sweep_count_after_done", sweep_count_out, pending_count);
                count_pending = 1'b0;
            end
            if (rd_en_out) begin
                if (exp_rd.size() == 0) check("rd_en_unexpected", rd_en_out, 0);
                else begin
                    e = exp_rd.pop_front();
                    check("rd_cycle", cyc, e.cyc);
                    check("rd_addr", rd_addr_out, e.addr);
                end
                rd_model.push_back(int'(rd_addr_out));
            end
            if (collide_valid_out) begin
                if (exp_cv.size() == 0) check("collide_valid_unexpected", collide_valid_out, 0);
                else begin
                    e = exp_cv.pop_front();
                    check("collide_valid_cycle", cyc, e.cyc);
                end
                if (rd_model.size() == 0) check("collide_without_read", collide_valid_out, 0);
                else begin
                    a = rd_model.pop_front();
                    pipe.push_back((a < NUM_CELLS) ? mem[a] : '0);
                end
            end
            if (wr_en_out) begin
                if (exp_wr.size() == 0) check("wr_en_unexpected", wr_en_out, 0);
                else begin
                    e = exp_wr.pop_front();
                    check("wr_cycle", cyc, e.cyc);
                    check("wr_addr", wr_addr_out, e.addr);
                end
                a = int'(wr_addr_out);
                if (pipe.size() == 0) check("wr_without_data", wr_en_out, 0);
                else if (a < NUM_CELLS) begin
                    dat = bounce(pipe.pop_front());
                    check("wr_data", dat, bounce(snap[a]));
                    mem[a] = dat;
                    wcnt[a]++;
                end
            end
            if (done_out) begin
                if (exp_done.size() == 0) check("done_unexpected", done_out, 0);
                else begin
                    dn = exp_done.pop_front();
                    check("done_cycle", cyc, dn.cyc);
                    pending_count = 16'(dn.count);
                    count_pending = 1'b1;
                end
                check("busy_during_done", busy_out, 0);
                for (int i = 0; i < NUM_CELLS; i++) begin
                    check("writes_per_cell", wcnt[i], 1);
                    wcnt[i] = 0;
                    snap[i] = mem[i];
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk_in);
        #2;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) next_cycle();
    endtask

    // Queue hand-computed events for one sweep started in cycle c0.
    task automatic push_sweep(input int c0, input int rdc[4], input bit writes,
                              input int done_rel, input int count);
        ev_t   e;
        done_t dn;
        for (int i = 0; i < 4; i++) begin
            e.addr = i;
            e.cyc = c0 + rdc[i];          exp_rd.push_back(e);
            e.cyc = c0 + rdc[i] + RD_LAT; exp_cv.push_back(e);
            if (writes) begin
                e.cyc = c0 + rdc[i] + D;  exp_wr.push_back(e);
            end
        end
        if (writes) begin
            dn.cyc = c0 + done_rel;
            dn.count = count;
            exp_done.push_back(dn);
        end
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_reads_left"},  exp_rd.size(),   0);
        check({tag, "_valids_left"}, exp_cv.size(),   0);
        check({tag, "_writes_left"}, exp_wr.size(),   0);
        check({tag, "_dones_left"},  exp_done.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_en"},       rd_en_out,         0);
        check({tag, "_rd_addr"},     rd_addr_out,       0);
        check({tag, "_collide"},     collide_valid_out, 0);
        check({tag, "_wr_en"},       wr_en_out,         0);
        check({tag, "_busy"},        busy_out,          0);
        check({tag, "_done"},        done_out,          0);
        check({tag, "_sweep_count"}, sweep_count_out,   0);
    endtask

    initial begin
        int c0;
        for (int i = 0; i < NUM_CELLS; i++) begin
            for (int d = 0; d < 9; d++) mem[i][d] = 8'((i << 4) + d + 1);
            snap[i] = mem[i];
            wcnt[i] = 0;
        end

        // Reset state
        #3;
        check_all_zero("reset");
        repeat (3) next_cycle();
        rst_in = 1'b0;
        next_cycle();

        // Plain sweep
        c0 = cyc;
        start_in = 1'b1;
        push_sweep(c0, '{1, 2, 3, 4}, 1'b1, 27, 1);
        next_cycle();
        start_in = 1'b0;
        check("busy_in_issue", busy_out, 1);
        wait_until(c0 + 32);
        check_drained("plain");

        // Pause for cycles 2-3
        c0 = cyc;
        start_in = 1'b1;
        push_sweep(c0, '{1, 4, 5, 6}, 1'b1, 29, 2);
        next_cycle();
        start_in = 1'b0;
        next_cycle();
        pause_in = 1'b1;
        next_cycle();
        next_cycle();
        pause_in = 1'b0;
        wait_until(c0 + 34);
        check_drained("pause");

        // start_in pulses in ISSUE and DRAIN are ignored
        c0 = cyc;
        start_in = 1'b1;
        push_sweep(c0, '{1, 2, 3, 4}, 1'b1, 27, 3);
        next_cycle();
        start_in = 1'b0;
        wait_until(c0 + 3);
        start_in = 1'b1;
        next_cycle();
        start_in = 1'b0;
        wait_until(c0 + 10);
        start_in = 1'b1;
        next_cycle();
        start_in = 1'b0;
        wait_until(c0 + 40);
        check_drained("ignored_start");

        // Reset mid-DRAIN aborts the sweep
        c0 = cyc;
        start_in = 1'b1;
        push_sweep(c0, '{1, 2, 3, 4}, 1'b0, 0, 0);
        next_cycle();
        start_in = 1'b0;
        wait_until(c0 + 10);
        check("busy_before_abort", busy_out, 1);
        rst_in = 1'b1;
        #1;
        check_all_zero("abort");
        next_cycle();
        rst_in = 1'b0;
        wait_until(c0 + 40);
        check("sweep_count_after_abort", sweep_count_out, 0);
        check_drained("abort");

        // Clean sweep after the abort
        c0 = cyc;
        start_in = 1'b1;
        push_sweep(c0, '{1, 2, 3, 4}, 1'b1, 27, 1);
        next_cycle();
        start_in = 1'b0;
        wait_until(c0 + 32);
        check_drained("post_abort");

        // Back-to-back sweeps with start held, count wrapping on the third
        c0 = cyc;
        start_in = 1'b1;
        push_sweep(c0,      '{1, 2, 3, 4}, 1'b1, 27, 2);
        push_sweep(c0 + 28, '{1, 2, 3, 4}, 1'b1, 27, 3);
        push_sweep(c0 + 56, '{1, 2, 3, 4}, 1'b1, 27, 0);
        wait_until(c0 + 60);
        force dut.sweep_count_q = 16'hFFFF;
        next_cycle();
        release dut.sweep_count_q;
        start_in = 1'b0;
        check("sweep_count_preloaded", sweep_count_out, 16'hFFFF);
        wait_until(c0 + 90);
        check("sweep_count_wrapped", sweep_count_out, 0);
        check_drained("back_to_back");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
